if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch initiator for the ROM block: owns the PC and drives the ROM enable and address.
- Captures the ROM's combinational read data into a registered fetch slot and hands it to decode over a valid/ready handshake.
- Handles jump redirects with flush, halt, and error detection for misaligned or out-of-range fetch addresses.
- Sits between the ROM and the decode stage in the pipeline.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- ROM_DEPTH, 64, number of 32-bit words in the ROM. A word index at or above this value is out of range.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- rom_ce_o  output  1  ROM chip enable.
- rom_addr_o  output  32  ROM word index, equal to pc[31:2]. The ROM is word-indexed, not byte-indexed.
- rom_inst_i  input  32  ROM read data; combinational, valid in the same cycle as rom_addr_o.
- jump_i  input  1  redirect request from execute.
- jump_addr_i  input  32  byte address of the redirect target.
- halt_i  input  1  stop issuing new fetches.
- valid_o  output  1  fetch slot holds an instruction.
- ready_i  input  1  decode accepts the slot this cycle.
- inst_o  output  32  fetched instruction.
- pc_o  output  32  byte address of inst_o.
- err_o  output  1  sticky fetch error: misaligned or out-of-range address.

Behaviour:
- Reset values (rst=1, sampled on clk): pc=RESET_PC, state=IDLE, rom_ce_o=0, valid_o=0, inst_o=0, pc_o=0, err_o=0. Reset overrides every other input.
- rom_addr_o = {2'b00, pc[31:2]}. It is driven combinationally from the pc register in every state.
- rom_ce_o = 1 only in the FETCH state.
- Slot free: free = !valid_o || ready_i.
- States:
  - IDLE: one cycle after reset, no fetch; next state is FETCH.
  - FETCH: if free, inst_o<=rom_inst_i, pc_o<=pc, valid_o<=1, pc<=pc+4. If not free, pc and the slot hold (backpressure), and rom_ce_o stays 1.
  - HALT: rom_ce_o=0, pc holds. A pending slot stays valid until accepted; after acceptance valid_o<=0.
- Latency: the instruction at pc appears on inst_o/valid_o one cycle after pc holds that value. With ready_i held at 1 the block sustains 1 instruction per cycle.
- Redirect (jump_i=1, any state except reset):
  - pc<=jump_addr_i.
  - valid_o<=0 (flush), regardless of ready_i. A transfer with valid_o&&ready_i in that same cycle still counts as completed.
  - No capture happens in that cycle.
  - Next state: FETCH, or HALT if halt_i is also 1.
  - A redirect taken in HALT resumes fetching from jump_addr_i.
- Halt: halt_i=1 in FETCH (no jump) completes that cycle's capture if free, then state<=HALT.
- Error checks, in FETCH or on redirect: misaligned (address[1:0]!=0) or out of range (address[31:2] >= ROM_DEPTH).
  - The offending address is loaded into pc but never fetched.
  - err_o<=1 (sticky until rst), valid_o<=0, state<=HALT.
  - A later redirect to a legal address resumes FETCH; err_o stays 1.
- Wrap-around: sequential increment past the last word (pc=4*ROM_DEPTH) is an out-of-range error. It never silently wraps to 0.
- Precedence: rst > jump_i > error > halt_i > sequential fetch.
- pc arithmetic is 32-bit modulo 2^32. The range check catches overflow.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, FETCH=2'd1, HALT=2'd2;
  - constants INST_NOP=32'h0000_0013 and WORD_SHIFT=2.
- One natural sub-module, if_pc_reg: the pc register with next-pc mux (reset/jump/+4/hold) and alignment/range check outputs.
- Slot register and FSM stay in if_fetch.

Test Plan:
- Reset, then ready_i=1 and ROM word k=k+1: IDLE for 1 cycle, rom_ce_o=0. Then inst_o=1,2,3 with pc_o=0,4,8 on consecutive cycles, and rom_addr_o=0,1,2.
- ready_i=0 for 3 cycles while valid_o=1 at pc_o=8: inst_o/pc_o stable, rom_addr_o stays 3. After release, pc_o=12 follows the next cycle.
- jump_i=1, jump_addr_i=32'h20 while valid_o=1 at pc_o=4: next cycle valid_o=0, rom_addr_o=8. The cycle after, pc_o=32'h20, inst_o=rom[8].
- jump_addr_i=32'h22: err_o=1, valid_o=0, rom_ce_o=0. A following jump to 32'h10 gives pc_o=32'h10 with err_o still 1.
- Sequential run to pc=252 (word 63): rom[63] is delivered. The next step to pc=256 sets err_o=1 and enters HALT with no fetch of word 64.
- halt_i=1 at pc_o=12 with ready_i=0: slot held and rom_ce_o=0. When ready_i=1, valid_o drops the next cycle. rst mid-HALT returns all outputs to reset values.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared encodings and the fetch-address legality check for the fetch stage.
package if_fetch_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  localparam logic [31:0] INST_NOP   = 32'h0000_0013;
  localparam int          WORD_SHIFT = 2;

  // Misaligned byte address, or word index beyond the ROM (also catches pc overflow).
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth);
    logic [31:0] word;
    word = addr >> WORD_SHIFT;
    return (addr[1:0] != 2'b00) || (word >= depth);
  endfunction
endpackage

// File: rtl/if_pc_reg.sv
// Program counter with reset/jump/+4/hold next-pc selection and legality flags.
module if_pc_reg
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  input  logic        advance,
  output logic [31:0] pc,
  output logic        pc_bad,
  output logic        jump_bad
);
  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else if (jump)
      pc <= jump_addr;
    else if (advance)
      pc <= pc + 32'd4;
  end

  assign pc_bad   = addr_bad(pc, ROM_DEPTH);
  assign jump_bad = addr_bad(jump_addr, ROM_DEPTH);
endmodule

// File: rtl/if_fetch.sv
// Fetch stage: drives the ROM from the pc and registers one instruction for decode.
// Backpressure holds pc and slot; redirects flush; bad addresses set sticky err_o and halt.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  input  logic        halt_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        err_o
);
  logic [1:0]  state;
  logic [31:0] pc;
  logic        pc_bad;
  logic        jump_bad;
  logic        free;
  logic        advance;

  assign free    = !valid_o || ready_i;
  assign advance = (state == FETCH) && free && !pc_bad;

  if_pc_reg #(
    .RESET_PC (RESET_PC),
    .ROM_DEPTH(ROM_DEPTH)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .jump     (jump_i),
    .jump_addr(jump_addr_i),
    .advance  (advance),
    .pc       (pc),
    .pc_bad   (pc_bad),
    .jump_bad (jump_bad)
  );

  // An illegal pc reached by increment is never presented to the ROM.
  assign rom_ce_o   = (state == FETCH) && !pc_bad;
  assign rom_addr_o = {2'b00, pc[31:2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid_o <= 1'b0;
      inst_o  <= 32'h0;
      pc_o    <= 32'h0;
      err_o   <= 1'b0;
    end else if (jump_i) begin
      valid_o <= 1'b0;
      if (jump_bad) begin
        err_o <= 1'b1;
        state <= HALT;
      end else begin
        state <= halt_i ? HALT : FETCH;
      end
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (pc_bad) begin
            err_o   <= 1'b1;
            valid_o <= 1'b0;
            state   <= HALT;
          end else begin
            if (free) begin
              inst_o  <= rom_inst_i;
              pc_o    <= pc;
              valid_o <= 1'b1;
            end
            if (halt_i)
              state <= HALT;
          end
        end
        HALT: begin
          if (ready_i)
            valid_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: ROM word k holds k+1; every check is hand-computed.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        halt_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        err_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign rom_inst_i = rom_addr_o + 32'd1;

  if_fetch #(
    .RESET_PC (32'h0000_0000),
    .ROM_DEPTH(64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_o   (rom_ce_o),
    .rom_addr_o (rom_addr_o),
    .rom_inst_i (rom_inst_i),
    .jump_i     (jump_i),
    .jump_addr_i(jump_addr_i),
    .halt_i     (halt_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .inst_o     (inst_o),
    .pc_o       (pc_o),
    .err_o      (err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, {31'b0, valid_o}, 32'd0);
    check({tag, "_inst"}, inst_o, 32'd0);
    check({tag, "_pc"}, pc_o, 32'd0);
    check({tag, "_err"}, {31'b0, err_o}, 32'd0);
    check({tag, "_ce"}, {31'b0, rom_ce_o}, 32'd0);
    check({tag, "_addr"}, rom_addr_o, 32'd0);
  endtask

  task automatic check_slot(input string tag, input logic v, input logic [31:0] inst, input logic [31:0] pc);
    check({tag, "_valid"}, {31'b0, valid_o}, {31'b0, v});
    check({tag, "_inst"}, inst_o, inst);
    check({tag, "_pc"}, pc_o, pc);
  endtask

  initial begin
    rst = 1'b1; ready_i = 1'b1; jump_i = 1'b0; jump_addr_i = 32'h0; halt_i = 1'b0;
    step();
    step();
    check_reset("reset");

    // IDLE -> FETCH, then streaming at one instruction per cycle
    rst = 1'b0;
    step();
    check("idle_exit_ce", {31'b0, rom_ce_o}, 32'd1);
    check("idle_exit_valid", {31'b0, valid_o}, 32'd0);
    check("idle_exit_addr", rom_addr_o, 32'd0);
    step();
    check_slot("seq0", 1'b1, 32'd1, 32'd0);
    check("seq0_addr", rom_addr_o, 32'd1);
    step();
    check_slot("seq1", 1'b1, 32'd2, 32'd4);
    check("seq1_addr", rom_addr_o, 32'd2);
    step();
    check_slot("seq2", 1'b1, 32'd3, 32'd8);
    check("seq2_addr", rom_addr_o, 32'd3);

    // Backpressure: slot and pc hold
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_slot("stall", 1'b1, 32'd3, 32'd8);
      check("stall_addr", rom_addr_o, 32'd3);
      check("stall_ce", {31'b0, rom_ce_o}, 32'd1);
    end
    ready_i = 1'b1;
    step();
    check_slot("release", 1'b1, 32'd4, 32'd12);
    check("release_addr", rom_addr_o, 32'd4);

    // Redirect flushes the slot, then fetches the target
    jump_i = 1'b1; jump_addr_i = 32'h20;
    step();
    jump_i = 1'b0;
    check("jump_flush_valid", {31'b0, valid_o}, 32'd0);
    check("jump_addr", rom_addr_o, 32'd8);
    step();
    check_slot("jump_tgt", 1'b1, 32'd9, 32'h20);

    // Misaligned redirect target
    jump_i = 1'b1; jump_addr_i = 32'h22;
    step();
    jump_i = 1'b0;
    check("misal_err", {31'b0, err_o}, 32'd1);
    check("misal_valid", {31'b0, valid_o}, 32'd0);
    check("misal_ce", {31'b0, rom_ce_o}, 32'd0);
    step();
    check("misal_halt_ce", {31'b0, rom_ce_o}, 32'd0);
    jump_i = 1'b1; jump_addr_i = 32'h10;
    step();
    jump_i = 1'b0;
    check("recover_valid", {31'b0, valid_o}, 32'd0);
    check("recover_ce", {31'b0, rom_ce_o}, 32'd1);
    step();
    check_slot("recover", 1'b1, 32'd5, 32'h10);
    check("recover_err_sticky", {31'b0, err_o}, 32'd1);

    // Reset clears the sticky error
    rst = 1'b1;
    step();
    check_reset("reset2");

    // Run off the end of the ROM
    rst = 1'b0; jump_i = 1'b1; jump_addr_i = 32'hF8;
    step();
    jump_i = 1'b0;
    check("end_jump_addr", rom_addr_o, 32'd62);
    step();
    check_slot("word62", 1'b1, 32'd63, 32'hF8);
    check("word62_err", {31'b0, err_o}, 32'd0);
    step();
    check_slot("word63", 1'b1, 32'd64, 32'hFC);
    check("word64_ce", {31'b0, rom_ce_o}, 32'd0);
    check("word64_addr", rom_addr_o, 32'd64);
    step();
    check("wrap_err", {31'b0, err_o}, 32'd1);
    check_slot("wrap", 1'b0, 32'd64, 32'hFC);
    check("wrap_ce", {31'b0, rom_ce_o}, 32'd0);
    step();
    check("wrap_hold_addr", rom_addr_o, 32'd64);

    // Halt with a held slot, then drain
    jump_i = 1'b1; jump_addr_i = 32'h0C;
    step();
    jump_i = 1'b0;
    step();
    check_slot("pre_halt", 1'b1, 32'd4, 32'd12);
    ready_i = 1'b0; halt_i = 1'b1;
    step();
    check_slot("halt_hold", 1'b1, 32'd4, 32'd12);
    check("halt_ce", {31'b0, rom_ce_o}, 32'd0);
    step();
    check_slot("halt_hold2", 1'b1, 32'd4, 32'd12);
    check("halt_addr", rom_addr_o, 32'd4);
    ready_i = 1'b1;
    step();
    check("halt_drain_valid", {31'b0, valid_o}, 32'd0);
    check("halt_drain_ce", {31'b0, rom_ce_o}, 32'd0);

    rst = 1'b1;
    step();
    check_reset("reset3");
    rst = 1'b0; halt_i = 1'b0;
    step();
    check("post_reset_ce", {31'b0, rom_ce_o}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
